// File: rtl/chacha20_pkg.sv
// chacha20_pkg: shared types, sizes and constants for the ChaCha20 core and its keystream consumer
package chacha20_pkg;
    localparam int KS_WORDS = 16;
    localparam int WORD_W   = 32;
    localparam int NONCE_W  = 96;
    localparam int BLOCK_W  = KS_WORDS * WORD_W;
    localparam int IDX_W    = $clog2(KS_WORDS);

    // "expand 32-byte k" words, shared with the core's initial state
    localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
    localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
    localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
    localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

    // Word 0 of a keystream block sits in the most significant 32 bits
    function automatic logic [WORD_W-1:0] ks_word(input logic [BLOCK_W-1:0] blk, input logic [IDX_W-1:0] idx);
        return blk[BLOCK_W - 1 - WORD_W * int'(idx) -: WORD_W];
    endfunction
endpackage

// File: rtl/chacha20_stream_xor_if.sv
// chacha20_stream_xor_if: message stream in/out plus the keystream request channel to the core
interface chacha20_stream_xor_if;
    import chacha20_pkg::*;

    logic               msg_start;
    logic [NONCE_W-1:0] nonce;
    logic               in_valid;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic               in_ready;
    logic               out_valid;
    logic [WORD_W-1:0]  out_data;
    logic               out_last;
    logic               out_ready;
    logic               ks_req;
    logic [NONCE_W-1:0] ks_nonce;
    logic [WORD_W-1:0]  ks_counter;
    logic [BLOCK_W-1:0] ks_block;
    logic               ks_done;

    // Environment side: message source, message sink and keystream core
    modport master (
        output msg_start, nonce, in_valid, in_data, in_last, out_ready, ks_block, ks_done,
        input  in_ready, out_valid, out_data, out_last, ks_req, ks_nonce, ks_counter
    );

    // XOR block side
    modport slave (
        input  msg_start, nonce, in_valid, in_data, in_last, out_ready, ks_block, ks_done,
        output in_ready, out_valid, out_data, out_last, ks_req, ks_nonce, ks_counter
    );
endinterface

// File: rtl/chacha20_ks_buffer.sv
// chacha20_ks_buffer: holds one 512-bit keystream block and selects the word at the current index
module chacha20_ks_buffer
    import chacha20_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_load,
    input  logic [BLOCK_W-1:0] i_block,
    input  logic [IDX_W-1:0]   i_idx,
    output logic [WORD_W-1:0]  o_word
);
    logic [BLOCK_W-1:0] r_buf;

    // Capture a whole block when the core delivers it
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_buf <= '0;
        else if (i_load)
            r_buf <= i_block;
    end

    assign o_word = ks_word(r_buf, i_idx);
endmodule

// File: rtl/chacha20_stream_xor.sv
// chacha20_stream_xor: XORs a 32-bit message stream with ChaCha20 keystream, fetching blocks on demand.
// Define CHACHA_CTR_WRAP_ERR_EN to stop with a sticky ctr_err instead of wrapping the block counter.
module chacha20_stream_xor
    import chacha20_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    chacha20_stream_xor_if.slave bus,
    output logic                 busy
`ifdef CHACHA_CTR_WRAP_ERR_EN
    ,
    output logic                 ctr_err
`endif
);
    state_t             r_state, w_state_nxt;
    logic [NONCE_W-1:0] r_nonce;
    logic [WORD_W-1:0]  r_ks_counter;
    logic [IDX_W-1:0]   r_word_idx;
    logic               r_out_valid;
    logic [WORD_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [WORD_W-1:0]  w_ks_word;
    logic               w_start;
    logic               w_load;
    logic               w_accept;
    logic               w_boundary;
    logic               w_wrap_stop;

    assign w_start    = (r_state == IDLE) && bus.msg_start;
    assign w_load     = (r_state == WAIT) && bus.ks_done;
    assign w_accept   = bus.in_valid && bus.in_ready;
    // Last word of a block consumed and the message continues: another block is needed
    assign w_boundary = w_accept && !bus.in_last && (r_word_idx == IDX_W'(KS_WORDS - 1));

`ifdef CHACHA_CTR_WRAP_ERR_EN
    logic r_ctr_err;

    assign w_wrap_stop = w_boundary && (&r_ks_counter);
    assign ctr_err     = r_ctr_err;

    // Sticky counter-exhaustion flag, cleared by the next accepted message start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_ctr_err <= 1'b0;
        else if (w_start)
            r_ctr_err <= 1'b0;
        else if (w_wrap_stop)
            r_ctr_err <= 1'b1;
    end
`else
    assign w_wrap_stop = 1'b0;
`endif

    chacha20_ks_buffer u_ks_buffer (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_load),
        .i_block (bus.ks_block),
        .i_idx   (r_word_idx),
        .o_word  (w_ks_word)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state: in_last beats the block boundary, so a final word never triggers a request
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.msg_start) w_state_nxt = REQ;
            REQ:     w_state_nxt = WAIT;
            WAIT:    if (bus.ks_done) w_state_nxt = STREAM;
            STREAM: begin
                if (w_accept && bus.in_last)
                    w_state_nxt = IDLE;
                else if (w_boundary)
                    w_state_nxt = w_wrap_stop ? IDLE : REQ;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Nonce and block counter for the core; held steady between request and delivery
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_nonce      <= '0;
            r_ks_counter <= '0;
        end else if (w_start) begin
            r_nonce      <= bus.nonce;
            r_ks_counter <= '0;
        end else if (w_boundary && !w_wrap_stop) begin
            r_ks_counter <= r_ks_counter + WORD_W'(1);
        end
    end

    // Position of the next keystream word inside the buffered block
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_word_idx <= '0;
        else if (w_load)
            r_word_idx <= '0;
        else if (w_accept)
            r_word_idx <= r_word_idx + IDX_W'(1);
    end

    // Output register, free to drain regardless of FSM state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data ^ w_ks_word;
            r_out_last  <= bus.in_last;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = (r_state == STREAM) && (!r_out_valid || bus.out_ready);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.ks_req     = (r_state == REQ);
    assign bus.ks_nonce   = r_nonce;
    assign bus.ks_counter = r_ks_counter;
    assign busy           = (r_state != IDLE);
endmodule

// File: tb/tb_chacha20_stream_xor.sv
// tb_chacha20_stream_xor: directed scenarios for the keystream XOR block, acting as source, sink and core
module tb_chacha20_stream_xor;
    import chacha20_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic busy;
`ifdef CHACHA_CTR_WRAP_ERR_EN
    logic ctr_err;
`endif
    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] req_ctr[$];
    logic [95:0] req_nonce[$];
    int          first_acc, last_acc, stall_acc;
    bit          timed_out;

    chacha20_stream_xor_if bus();

    chacha20_stream_xor dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus),
        .busy   (busy)
`ifdef CHACHA_CTR_WRAP_ERR_EN
        ,
        .ctr_err(ctr_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] key_word(input logic [31:0] c, input int i);
        return (c * 32'h01000193) ^ (32'h11111111 * 32'(i)) ^ 32'hA5A50F0F;
    endfunction

    function automatic logic [511:0] mk_block(input logic [31:0] c);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32 * i -: 32] = key_word(c, i);
        return b;
    endfunction

    function automatic logic [31:0] data_word(input int i);
        return 32'h10000000 + 32'h01010101 * 32'(i);
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        bus.msg_start = 0; bus.nonce = '0; bus.in_valid = 0; bus.in_data = '0; bus.in_last = 0;
        bus.out_ready = 0; bus.ks_block = '0; bus.ks_done = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Streams n words, answering every ks_req one cycle later with mk_block(ks_counter)
    task automatic run_msg(input int n, input int n_exp, input logic [95:0] nn, input int stall_at,
                           input int stall_len, input bit stray, input bit force_max);
        int in_cnt = 0, out_cnt = 0, cyc = 0, stall_left = stall_len;
        bit pend = 0, forced = 0, stray_done = 0;
        got_data.delete(); got_last.delete(); req_ctr.delete(); req_nonce.delete();
        first_acc = -1; last_acc = -1; stall_acc = 0; timed_out = 0;
        bus.nonce = nn; bus.msg_start = 1;
        @(negedge clk);
        while (out_cnt < n_exp) begin
            if (cyc >= 400) begin timed_out = 1; break; end
            bus.ks_done = 0; bus.msg_start = 0; bus.nonce = nn;
            if (forced) begin release dut.r_ks_counter; forced = 0; end
            if (pend) begin bus.ks_block = mk_block(bus.ks_counter); bus.ks_done = 1; pend = 0; end
            if (bus.ks_req) begin
                req_ctr.push_back(bus.ks_counter);
                req_nonce.push_back(bus.ks_nonce);
                pend = 1;
                if (force_max && req_ctr.size() == 1) begin force dut.r_ks_counter = 32'hFFFFFFFF; forced = 1; end
            end
            if (stray && !stray_done && in_cnt == 5) begin
                bus.msg_start = 1; bus.nonce = ~nn; bus.ks_done = 1; bus.ks_block = '0; stray_done = 1;
            end
            bus.out_ready = 1;
            if (in_cnt >= stall_at && stall_left > 0) begin bus.out_ready = 0; stall_left--; end
            bus.in_valid = in_cnt < n;
            bus.in_data = data_word(in_cnt);
            bus.in_last = in_cnt == n - 1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got_data.push_back(bus.out_data); got_last.push_back(bus.out_last); out_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                if (!bus.out_ready) stall_acc++;
                in_cnt++;
            end
            cyc++;
            @(negedge clk);
        end
        if (forced) release dut.r_ks_counter;
        bus.in_valid = 0; bus.in_last = 0; bus.ks_done = 0; bus.msg_start = 0; bus.out_ready = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        bus.msg_start = 0; bus.in_valid = 0; bus.out_ready = 1; bus.ks_done = 0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.ks_req, bus.ks_nonce, bus.ks_counter, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h out_last=%b ks_req=%b ks_nonce=%h ks_counter=%h busy=%b, all must be 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.ks_req, bus.ks_nonce, bus.ks_counter, busy);
        end
`ifdef CHACHA_CTR_WRAP_ERR_EN
        n_checks++;
        if (ctr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctr_err: got %b want 0", ctr_err); end
`endif
        do_reset();
    endtask

    task automatic test_single_word();
        logic [511:0] blk = '0;
        blk[511 -: 32] = 32'hDEADBEEF;
        bus.nonce = 96'h000000000000004A00000000; bus.msg_start = 1; bus.out_ready = 1;
        @(negedge clk);
        bus.msg_start = 0;
        n_checks++;
        if (bus.ks_req !== 1'b1 || bus.ks_counter !== 32'd0) begin
            n_fail++; $display("FAIL single_req: ks_req=%b ks_counter=%h want 1/0", bus.ks_req, bus.ks_counter);
        end
        n_checks++;
        if (bus.ks_nonce !== 96'h000000000000004A00000000) begin
            n_fail++; $display("FAIL single_nonce: got %h want 000000000000004a00000000", bus.ks_nonce);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ks_req !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_wait: ks_req=%b busy=%b in_ready=%b want 0/1/0", bus.ks_req, busy, bus.in_ready);
        end
        bus.ks_block = blk; bus.ks_done = 1;
        @(negedge clk);
        bus.ks_done = 0;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
        bus.in_valid = 1; bus.in_data = 32'h12345678; bus.in_last = 1;
        @(negedge clk);
        bus.in_valid = 0; bus.in_last = 0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hCC99E897 || bus.out_last !== 1'b1) begin
            n_fail++; $display("FAIL single_out: valid=%b data=%h last=%b want 1/cc99e897/1", bus.out_valid, bus.out_data, bus.out_last);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: out_valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_multi_block();
        int bad = 0;
        run_msg(20, 20, 96'h0102030405060708090A0B0C, 1000, 0, 0, 0);
        n_checks++;
        if (timed_out || got_data.size() != 20) begin
            n_fail++; $display("FAIL multi_count: timeout=%0d words=%0d want 0/20", timed_out, got_data.size());
        end
        n_checks++;
        if (req_ctr.size() != 2 || req_ctr[0] !== 32'd0 || req_ctr[1] !== 32'd1) begin
            n_fail++; $display("FAIL multi_reqs: count=%0d want 2 with counters 0,1", req_ctr.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== (data_word(i) ^ key_word(i / 16, i % 16)) || got_last[i] !== (i == 19)) begin
                n_fail++; bad++;
                $display("FAIL multi_word%0d: data=%h last=%b want %h/%b", i, got_data[i], got_last[i],
                         data_word(i) ^ key_word(i / 16, i % 16), i == 19);
            end
        end
        n_checks++;
        if (last_acc - first_acc != 21) begin
            n_fail++; $display("FAIL multi_span: accept span %0d cycles want 21", last_acc - first_acc);
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL multi_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        run_msg(10, 10, 96'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF, 4, 5, 0, 0);
        n_checks++;
        if (timed_out || got_data.size() != 10) begin
            n_fail++; $display("FAIL bp_count: timeout=%0d words=%0d want 0/10", timed_out, got_data.size());
        end
        n_checks++;
        if (stall_acc != 0) begin n_fail++; $display("FAIL bp_stall_accept: %0d words accepted while stalled, want 0", stall_acc); end
        n_checks++;
        if (last_acc - first_acc != 14) begin
            n_fail++; $display("FAIL bp_span: accept span %0d cycles want 14", last_acc - first_acc);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== (data_word(i) ^ key_word(0, i))) begin
                n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_data[i], data_word(i) ^ key_word(0, i));
            end
        end
    endtask

    task automatic test_stray_inputs();
        run_msg(18, 18, 96'h123456789ABCDEF011223344, 1000, 0, 1, 0);
        n_checks++;
        if (timed_out || got_data.size() != 18) begin
            n_fail++; $display("FAIL stray_count: timeout=%0d words=%0d want 0/18", timed_out, got_data.size());
        end
        n_checks++;
        if (req_ctr.size() != 2 || req_ctr[1] !== 32'd1 || req_nonce[1] !== 96'h123456789ABCDEF011223344) begin
            n_fail++; $display("FAIL stray_req: count=%0d want 2, second with counter 1 and original nonce", req_ctr.size());
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== (data_word(i) ^ key_word(i / 16, i % 16))) begin
                n_fail++; $display("FAIL stray_word%0d: got %h want %h", i, got_data[i], data_word(i) ^ key_word(i / 16, i % 16));
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.nonce = 96'h5555_6666_7777_8888_9999_AAAA; bus.msg_start = 1; bus.out_ready = 1;
        @(negedge clk);
        bus.msg_start = 0;
        @(negedge clk);
        bus.ks_block = mk_block(0); bus.ks_done = 1;
        @(negedge clk);
        bus.ks_done = 0; bus.in_valid = 1; bus.in_last = 0;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = data_word(i);
            @(negedge clk);
        end
        bus.in_valid = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || bus.ks_counter !== 32'd1) begin
            n_fail++; $display("FAIL rstmid_pre: busy=%b ks_counter=%h want 1/1", busy, bus.ks_counter);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, bus.ks_req, bus.ks_nonce, bus.ks_counter, busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: out_valid=%b out_data=%h ks_nonce=%h ks_counter=%h busy=%b, all must be 0",
                     bus.out_valid, bus.out_data, bus.ks_nonce, bus.ks_counter, busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus.nonce = 96'h1; bus.msg_start = 1;
        @(negedge clk);
        bus.msg_start = 0;
        n_checks++;
        if (bus.ks_req !== 1'b1 || bus.ks_counter !== 32'd0 || bus.ks_nonce !== 96'h1) begin
            n_fail++; $display("FAIL rstmid_restart: ks_req=%b ks_counter=%h ks_nonce=%h want 1/0/1", bus.ks_req, bus.ks_counter, bus.ks_nonce);
        end
        do_reset();
    endtask

    task automatic test_counter_wrap();
`ifdef CHACHA_CTR_WRAP_ERR_EN
        run_msg(17, 16, 96'hFACE, 1000, 0, 0, 1);
        n_checks++;
        if (timed_out || got_data.size() != 16 || req_ctr.size() != 1) begin
            n_fail++; $display("FAIL wrap_err_count: timeout=%0d words=%0d reqs=%0d want 0/16/1", timed_out, got_data.size(), req_ctr.size());
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (ctr_err !== 1'b1 || busy !== 1'b0 || bus.ks_req !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL wrap_err_state: ctr_err=%b busy=%b ks_req=%b in_ready=%b want 1/0/0/0", ctr_err, busy, bus.ks_req, bus.in_ready);
        end
        bus.msg_start = 1;
        @(negedge clk);
        bus.msg_start = 0;
        n_checks++;
        if (ctr_err !== 1'b0 || bus.ks_counter !== 32'd0) begin
            n_fail++; $display("FAIL wrap_err_clear: ctr_err=%b ks_counter=%h want 0/0", ctr_err, bus.ks_counter);
        end
        do_reset();
`else
        run_msg(17, 17, 96'hFACE, 1000, 0, 0, 1);
        n_checks++;
        if (timed_out || got_data.size() != 17 || req_ctr.size() != 2) begin
            n_fail++; $display("FAIL wrap_count: timeout=%0d words=%0d reqs=%0d want 0/17/2", timed_out, got_data.size(), req_ctr.size());
        end
        n_checks++;
        if (req_ctr.size() == 2 && req_ctr[1] !== 32'd0) begin
            n_fail++; $display("FAIL wrap_counter: second request counter %h want 0", req_ctr[1]);
        end
        for (int i = 0; i < got_data.size(); i++) begin
            n_checks++;
            if (got_data[i] !== (data_word(i) ^ key_word(i < 16 ? 32'hFFFFFFFF : 32'h0, i % 16))) begin
                n_fail++; $display("FAIL wrap_word%0d: got %h want %h", i, got_data[i],
                                   data_word(i) ^ key_word(i < 16 ? 32'hFFFFFFFF : 32'h0, i % 16));
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_multi_block();
        test_backpressure();
        test_stray_inputs();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
